// File: rtl/msrv32_fetch_ctrl.sv
// MSRV32 fetch controller: sequences instruction fetch, tracks the PC of the
// instruction presented to decode, and drives the instruction mux flush so
// that NOP bubbles appear on reset, memory wait states and redirects.
module msrv32_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        ms_riscv32_mp_instr_hready_in,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] imaddr_out,
  output logic        imem_req_out,
  output logic [31:0] pc_out,
  output logic        flush_out,
  output logic        instr_valid_out,
  output logic        misaligned_out
);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_FETCH,
    ST_WAIT,
    ST_REDIRECT
  } state_t;

  // Counter reload: the redirect cycle itself plus the first fetch cycle at
  // the target already account for one bubble, so REDIRECT lasts one less.
  localparam logic [2:0] CNT_RELOAD  = 3'(FLUSH_CYCLES - 1);
  localparam logic       GO_REDIRECT = (FLUSH_CYCLES > 1);

  state_t      state;
  logic [31:0] fetch_pc;
  logic [2:0]  bubble_cnt;

  // Force a redirect target onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Sequential fetch address; wraps modulo 2^32 without any flag.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign imaddr_out = fetch_pc;

  // Fetch state machine with all outputs registered alongside the state.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state           <= ST_RESET;
      fetch_pc        <= BOOT_ADDR;
      pc_out          <= BOOT_ADDR;
      flush_out       <= 1'b1;
      imem_req_out    <= 1'b0;
      instr_valid_out <= 1'b0;
      misaligned_out  <= 1'b0;
      bubble_cnt      <= 3'd0;
    end else begin
      misaligned_out <= 1'b0;
      if (state == ST_RESET) begin
        state        <= ST_FETCH;
        imem_req_out <= 1'b1;
      end else if (redirect_in) begin
        // Redirect wins over stall and over any data returned this cycle.
        fetch_pc        <= align_pc(redirect_pc_in);
        flush_out       <= 1'b1;
        instr_valid_out <= 1'b0;
        bubble_cnt      <= CNT_RELOAD;
        misaligned_out  <= |redirect_pc_in[1:0];
        state           <= GO_REDIRECT ? ST_REDIRECT : ST_FETCH;
        imem_req_out    <= ~GO_REDIRECT;
      end else begin
        case (state)
          ST_FETCH, ST_WAIT: begin
            if (!stall_in) begin
              if (ms_riscv32_mp_instr_hready_in) begin
                pc_out          <= fetch_pc;
                fetch_pc        <= next_pc(fetch_pc);
                flush_out       <= 1'b0;
                instr_valid_out <= 1'b1;
                state           <= ST_FETCH;
              end else begin
                flush_out       <= 1'b1;
                instr_valid_out <= 1'b0;
                state           <= ST_WAIT;
              end
            end
          end
          ST_REDIRECT: begin
            if (bubble_cnt <= 3'd1) begin
              bubble_cnt   <= 3'd0;
              state        <= ST_FETCH;
              imem_req_out <= 1'b1;
            end else begin
              bubble_cnt <= bubble_cnt - 3'd1;
            end
          end
          default: state <= ST_RESET;
        endcase
      end
    end
  end

endmodule

// File: doc/msrv32_fetch_ctrl.md
Name: msrv32_fetch_ctrl

Overview:
- Sequences instruction fetch for the MSRV32 core.
- Generates the fetch address and request toward instruction memory, and tracks the PC of the instruction currently presented to decode.
- Drives the flush input of msrv32_instruction_mux, inserting NOP bubbles on reset, memory wait states and control-flow redirects.
- Sits between the PC/branch logic and the instruction mux, in the fetch stage.

Parameters:
- BOOT_ADDR, 32'h0000_0000: first fetch address after reset; low two bits must be 0.
- FLUSH_CYCLES, 1: number of bubble cycles issued after a redirect (1..7).

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on rising edge.
- ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-high.
- ms_riscv32_mp_instr_hready_in  input  1  instruction memory has valid data for imaddr_out this cycle.
- stall_in  input  1  downstream stall; hold fetch state.
- redirect_in  input  1  branch, jump or trap taken this cycle.
- redirect_pc_in  input  32  redirect target.
- imaddr_out  output  32  instruction memory address (fetch PC).
- imem_req_out  output  1  fetch request valid.
- pc_out  output  32  PC of the instruction presented to the instruction mux.
- flush_out  output  1  to instruction mux flush_in; 1 = present NOP.
- instr_valid_out  output  1  pc_out/instruction pair is valid.
- misaligned_out  output  1  one-cycle pulse when redirect_pc_in[1:0] != 0.

Behaviour:
- Reset values (asynchronous, while ms_riscv32_mp_rst_in=1):
  - state=RESET, fetch_pc=BOOT_ADDR, pc_out=BOOT_ADDR
  - flush_out=1, imem_req_out=0, instr_valid_out=0, misaligned_out=0, bubble counter=0
- Reset asserted mid-operation aborts everything immediately.
- All outputs are registered except imaddr_out, which is fetch_pc.
- States: RESET, FETCH, WAIT, REDIRECT.
- RESET:
  - Unconditionally moves to FETCH on the first clock edge after reset deasserts.
  - flush_out=1 during this cycle.
- FETCH:
  - imem_req_out=1 (registered on entry and held).
  - hready=1, stall=0: pc_out<=fetch_pc, fetch_pc<=fetch_pc+4, flush_out<=0, instr_valid_out<=1. Stay in FETCH. Back-to-back fetches give one instruction per cycle.
  - hready=0, stall=0: go to WAIT; flush_out<=1, instr_valid_out<=0, fetch_pc unchanged.
  - stall=1: all registers hold; hready is ignored and the memory must re-present the data.
- WAIT:
  - imem_req_out=1 and imaddr_out=fetch_pc are held.
  - Bubbles continue: flush_out=1, instr_valid_out=0.
  - On hready=1 and stall=0: same update as the FETCH accept case, then go to FETCH.
- Redirect:
  - Highest priority in FETCH and WAIT, and overrides stall_in.
  - Effects: fetch_pc<={redirect_pc_in[31:2],2'b00}, flush_out<=1, instr_valid_out<=0, counter<=FLUSH_CYCLES-1.
  - Next state: REDIRECT when FLUSH_CYCLES>1, otherwise FETCH.
  - An instruction returned in the same cycle (hready=1) is discarded; pc_out does not update.
  - misaligned_out<=1 for one cycle if redirect_pc_in[1:0]!=0. The target is still force-aligned.
- REDIRECT:
  - imem_req_out=0, flush_out=1.
  - Counter decrements each cycle; at 0, go to FETCH.
  - A new redirect_in restarts the counter at FLUSH_CYCLES-1 and reloads fetch_pc.
  - stall_in is ignored in this state.
- Arithmetic: fetch_pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- flush_out is the exact complement of instr_valid_out in every state.

Test Plan:
- Reset with BOOT_ADDR=0, then release, hready=1 constant → one RESET cycle with flush_out=1; then imaddr_out sequence 0,4,8,C; pc_out follows one cycle later; flush_out=0 from the second cycle after release.
- hready low for 3 cycles at fetch_pc=0x10 → imaddr_out held at 0x10; flush_out=1 and instr_valid_out=0 for 3 cycles; accept at 0x10 when hready rises, then 0x14.
- redirect_in=1 with redirect_pc_in=0x0000_0102 and hready=1 in the same cycle, FLUSH_CYCLES=2 → misaligned_out pulse; returned instruction discarded; 2 flush cycles; next imaddr_out=0x0000_0100.
- stall_in=1 for 2 cycles at fetch_pc=0x20 → pc_out, imaddr_out and flush_out frozen; a redirect_in during the stall still redirects.
- fetch_pc=0xFFFF_FFFC accepted → next imaddr_out=0x0000_0000.
- Reset asserted while in REDIRECT → immediate return to reset values, imaddr_out=BOOT_ADDR.
